// File: rtl/fp_norm_round_pkg.sv
// Shared constants, flag struct and rounding helper for the binary32 normalize/round block.
package fp_defs;

    localparam int C_EXP           = 8;
    localparam int C_MANT          = 23;
    localparam int C_EXP_PRENORM   = 10;
    localparam int C_MANT_PRENORM  = 48;
    localparam int C_BIAS          = 127;
    localparam int C_SUB_SHIFT_MAX = 25;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
        logic zero;
    } fp_flags_t;

    // Round to nearest, ties to even: bump only above half, or at exactly half with odd lsb.
    function automatic logic rne_round_up(input logic lsb, input logic guard, input logic sticky);
        return guard & (sticky | lsb);
    endfunction

endpackage

// File: rtl/fp_norm_round_lzc.sv
// fp_lzc: combinational leading-zero counter with all-zero flag.
module fp_lzc #(
    parameter int WIDTH = 48,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             all_zero
);

    // Scan upward so the highest set bit writes last and wins.
    always_comb begin
        count    = CNT_W'(WIDTH);
        all_zero = ~|data;
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// fp_norm_round: 2-stage normalize, round-to-nearest-even and pack to IEEE-754 binary32.
// Define FP_NORM_SUBNORMAL_EN for gradual underflow; otherwise underflow flushes to signed zero.
module fp_norm_round #(
    parameter int C_EXP          = fp_defs::C_EXP,
    parameter int C_MANT         = fp_defs::C_MANT,
    parameter int C_EXP_PRENORM  = fp_defs::C_EXP_PRENORM,
    parameter int C_MANT_PRENORM = fp_defs::C_MANT_PRENORM
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    input  logic                            sign_prenorm_i,
    input  logic signed [C_EXP_PRENORM-1:0] exp_prenorm_i,
    input  logic [C_MANT_PRENORM-1:0]       mant_prenorm_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [C_EXP+C_MANT:0]           result_o,
    output fp_defs::fp_flags_t              flags_o
);

    import fp_defs::*;

    localparam int W     = C_MANT_PRENORM;
    localparam int E     = C_EXP_PRENORM;
    localparam int CW    = $clog2(W + 1);
    localparam int GUARD = W - 3 - C_MANT;

    localparam logic signed [E-1:0] EXP_ZERO = '0;
    localparam logic signed [E-1:0] EXP_MAX  = E'(2 * C_BIAS + 1);

    // Stage 1 keeps the significand with the carry bit dropped: hidden bit at W-2.
    typedef struct packed {
        logic         sign;
        logic [E-1:0] exp;
        logic [W-2:0] mant;
    } s1_t;

    typedef struct packed {
        logic [C_EXP+C_MANT:0] result;
        fp_flags_t             flags;
    } s2_t;

    logic s1_valid;
    logic s2_valid;
    logic s2_ready;
    s1_t  s1_d;
    s1_t  s1_q;
    s2_t  s2_d;
    s2_t  s2_q;

    assign s2_ready = ~s2_valid | ready_i;
    assign ready_o  = ~s1_valid | s2_ready;
    assign valid_o  = s2_valid;
    assign result_o = s2_q.result;
    assign flags_o  = s2_q.flags;

    // ---------------- S1: normalize ----------------
    logic [CW-1:0]       lz;
    logic                mant_zero;
    logic [CW-1:0]       lshift;
    logic signed [E-1:0] norm_exp;
    logic [W-2:0]        norm_mant;

    fp_lzc #(
        .WIDTH (W),
        .CNT_W (CW)
    ) u_lzc (
        .data     (mant_prenorm_i),
        .count    (lz),
        .all_zero (mant_zero)
    );

    always_comb begin
        lshift    = '0;
        norm_exp  = exp_prenorm_i;
        norm_mant = mant_prenorm_i[W-2:0];
        if (mant_zero) begin
            norm_exp  = '0;
            norm_mant = '0;
        end else if (lz == '0) begin
            norm_exp  = exp_prenorm_i + E'(1);
            norm_mant = {mant_prenorm_i[W-1:2], mant_prenorm_i[1] | mant_prenorm_i[0]};
        end else if (lz > CW'(1)) begin
            lshift    = lz - CW'(1);
            norm_exp  = exp_prenorm_i - E'(lshift);
            norm_mant = mant_prenorm_i[W-2:0] << lshift;
        end
    end

    always_comb begin
        s1_d      = '0;
        s1_d.sign = sign_prenorm_i;
        s1_d.exp  = norm_exp;
        s1_d.mant = norm_mant;
    end

    // ---------------- S2: round and pack ----------------
    logic signed [E-1:0] s1_exp;
    logic signed [E-1:0] exp_base;
    logic signed [E-1:0] exp_fin;
    logic                is_zero;
    logic                is_under;
    logic [W-2:0]        rnd_sig;
    logic                sub_sticky;
    logic [C_MANT-1:0]   frac;
    logic                guard;
    logic                sticky;
    logic                inc;
    logic [C_MANT:0]     rnd;

`ifdef FP_NORM_SUBNORMAL_EN
    localparam int SH_W = $clog2(C_SUB_SHIFT_MAX + 1);
    localparam logic signed [E-1:0] EXP_ONE = E'(1);
    localparam logic signed [E-1:0] SUB_CAP = E'(C_SUB_SHIFT_MAX);

    logic signed [E-1:0] sh_amt_s;
    logic [SH_W-1:0]     sh_amt;
    logic [W-2:0]        sh_mask;
`endif

    always_comb begin
        s1_exp     = s1_q.exp;
        is_zero    = ~s1_q.mant[W-2];
        is_under   = (s1_exp <= EXP_ZERO);
        rnd_sig    = s1_q.mant;
        sub_sticky = 1'b0;
`ifdef FP_NORM_SUBNORMAL_EN
        sh_amt_s = EXP_ONE - s1_exp;
        if (sh_amt_s > SUB_CAP || sh_amt_s < EXP_ZERO) begin
            sh_amt = SH_W'(C_SUB_SHIFT_MAX);
        end else begin
            sh_amt = SH_W'(sh_amt_s);
        end
        sh_mask = ~({(W-1){1'b1}} << sh_amt);
        if (is_under) begin
            rnd_sig    = s1_q.mant >> sh_amt;
            sub_sticky = |(s1_q.mant & sh_mask);
        end
`endif
        frac   = rnd_sig[W-3 -: C_MANT];
        guard  = rnd_sig[GUARD];
        sticky = (|rnd_sig[GUARD-1:0]) | sub_sticky;
        inc    = rne_round_up(frac[0], guard, sticky);
        rnd    = {1'b0, frac} + (C_MANT+1)'(inc);

        // A fraction carry bumps the exponent field; for subnormals it lands the value at exponent 1.
        exp_base = is_under ? $signed(E'(rnd_sig[W-2])) : s1_exp;
        exp_fin  = exp_base + $signed(E'(rnd[C_MANT]));

        s2_d = '0;
        if (is_zero) begin
            s2_d.flags.zero = 1'b1;
        end else if (is_under) begin
`ifdef FP_NORM_SUBNORMAL_EN
            s2_d.result          = {s1_q.sign, C_EXP'(exp_fin), rnd[C_MANT-1:0]};
            s2_d.flags.underflow = 1'b1;
            s2_d.flags.inexact   = guard | sticky;
`else
            s2_d.result          = {s1_q.sign, {(C_EXP+C_MANT){1'b0}}};
            s2_d.flags.underflow = 1'b1;
            s2_d.flags.inexact   = 1'b1;
`endif
        end else if (exp_fin >= EXP_MAX) begin
            s2_d.result         = {s1_q.sign, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
            s2_d.flags.overflow = 1'b1;
            s2_d.flags.inexact  = 1'b1;
        end else begin
            s2_d.result        = {s1_q.sign, C_EXP'(exp_fin), rnd[C_MANT-1:0]};
            s2_d.flags.inexact = guard | sticky;
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (ready_o) begin
                s1_valid <= valid_i;
                if (valid_i) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_q <= s2_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed self-checking bench for fp_norm_round (honours FP_NORM_SUBNORMAL_EN for expected values).
module tb_fp_norm_round;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_i;
    logic               ready_o;
    logic               sign_in;
    logic signed [9:0]  exp_in;
    logic [47:0]        mant_in;
    logic               valid_o;
    logic               ready_i;
    logic [31:0]        result;
    logic [3:0]         flags;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string             name;
        logic              sign;
        logic signed [9:0] e;
        logic [47:0]       m;
        logic [31:0]       r;
        logic [3:0]        f;
    } vec_t;

    always #5 clk = ~clk;

    fp_norm_round dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .sign_prenorm_i (sign_in),
        .exp_prenorm_i  (exp_in),
        .mant_prenorm_i (mant_in),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .result_o       (result),
        .flags_o        (flags)
    );

    // Drives one operand into an idle-or-draining pipe and samples the result two edges later.
    task automatic run_op(input logic s, input logic signed [9:0] e, input logic [47:0] m,
                          output logic [31:0] res, output logic [3:0] fl, output logic lat_ok);
        @(negedge clk);
        sign_in = s;
        exp_in  = e;
        mant_in = m;
        valid_i = 1'b1;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        lat_ok  = (valid_o === 1'b0);
        @(posedge clk);
        #1;
        lat_ok = lat_ok && (valid_o === 1'b1);
        res    = result;
        fl     = flags;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++;
        if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
        checks++;
        if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    endtask

    task automatic test_normalize_round();
        vec_t        v[8];
        logic [31:0] res;
        logic [3:0]  fl;
        logic        lat;
        v[0] = '{"one",          1'b0, 10'sd127, 48'h4000_0000_0000, 32'h3F80_0000, 4'b0000};
        v[1] = '{"lshift2",      1'b0, 10'sd130, 48'h1000_0000_0000, 32'h4000_0000, 4'b0000};
        v[2] = '{"lshift2_neg",  1'b1, 10'sd130, 48'h1000_0000_0000, 32'hC000_0000, 4'b0000};
        v[3] = '{"tie_even",     1'b0, 10'sd127, 48'h4000_0040_0000, 32'h3F80_0000, 4'b0010};
        v[4] = '{"tie_odd",      1'b0, 10'sd127, 48'h4000_00C0_0000, 32'h3F80_0002, 4'b0010};
        v[5] = '{"sticky_only",  1'b0, 10'sd127, 48'h4000_0010_0000, 32'h3F80_0000, 4'b0010};
        v[6] = '{"above_half",   1'b0, 10'sd127, 48'h4000_0050_0000, 32'h3F80_0001, 4'b0010};
        v[7] = '{"round_carry",  1'b0, 10'sd127, 48'h7FFF_FFC0_0000, 32'h4000_0000, 4'b0010};
        for (int i = 0; i < 8; i++) begin
            run_op(v[i].sign, v[i].e, v[i].m, res, fl, lat);
            checks++;
            if (lat !== 1'b1) begin errors++; $display("FAIL %s latency: got ok=%b expected ok=1 (2 cycles)", v[i].name, lat); end
            checks++;
            if (res !== v[i].r) begin errors++; $display("FAIL %s result: got %h expected %h", v[i].name, res, v[i].r); end
            checks++;
            if (fl !== v[i].f) begin errors++; $display("FAIL %s flags: got %b expected %b", v[i].name, fl, v[i].f); end
        end
    endtask

    task automatic test_carry_overflow();
        vec_t        v[4];
        logic [31:0] res;
        logic [3:0]  fl;
        logic        lat;
        v[0] = '{"carry",        1'b0, 10'sd127, 48'h8000_0000_0000, 32'h4000_0000, 4'b0000};
        v[1] = '{"carry_ovf",    1'b0, 10'sd254, 48'h8000_0000_0000, 32'h7F80_0000, 4'b1010};
        v[2] = '{"max_exp",      1'b1, 10'sd254, 48'h4000_0000_0000, 32'hFF00_0000, 4'b0000};
        v[3] = '{"round_ovf",    1'b1, 10'sd254, 48'h7FFF_FFC0_0000, 32'hFF80_0000, 4'b1010};
        for (int i = 0; i < 4; i++) begin
            run_op(v[i].sign, v[i].e, v[i].m, res, fl, lat);
            checks++;
            if (lat !== 1'b1) begin errors++; $display("FAIL %s latency: got ok=%b expected ok=1 (2 cycles)", v[i].name, lat); end
            checks++;
            if (res !== v[i].r) begin errors++; $display("FAIL %s result: got %h expected %h", v[i].name, res, v[i].r); end
            checks++;
            if (fl !== v[i].f) begin errors++; $display("FAIL %s flags: got %b expected %b", v[i].name, fl, v[i].f); end
        end
    endtask

    task automatic test_zero_underflow();
        vec_t        v[4];
        logic [31:0] res;
        logic [3:0]  fl;
        logic        lat;
        v[0] = '{"zero_neg",     1'b1, 10'sd5,   48'h0,              32'h0000_0000, 4'b0001};
`ifdef FP_NORM_SUBNORMAL_EN
        v[1] = '{"under_exp1",   1'b0, 10'sd1,   48'h1000_0000_0000, 32'h0020_0000, 4'b0100};
        v[2] = '{"under_exp0",   1'b1, 10'sd0,   48'h4000_0000_0000, 32'h8040_0000, 4'b0100};
`else
        v[1] = '{"under_exp1",   1'b0, 10'sd1,   48'h1000_0000_0000, 32'h0000_0000, 4'b0110};
        v[2] = '{"under_exp0",   1'b1, 10'sd0,   48'h4000_0000_0000, 32'h8000_0000, 4'b0110};
`endif
        v[3] = '{"under_deep",   1'b0, -10'sd40, 48'h4000_0000_0000, 32'h0000_0000, 4'b0110};
        for (int i = 0; i < 4; i++) begin
            run_op(v[i].sign, v[i].e, v[i].m, res, fl, lat);
            checks++;
            if (lat !== 1'b1) begin errors++; $display("FAIL %s latency: got ok=%b expected ok=1 (2 cycles)", v[i].name, lat); end
            checks++;
            if (res !== v[i].r) begin errors++; $display("FAIL %s result: got %h expected %h", v[i].name, res, v[i].r); end
            checks++;
            if (fl !== v[i].f) begin errors++; $display("FAIL %s flags: got %b expected %b", v[i].name, fl, v[i].f); end
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] m[4];
        logic [31:0] er[4];
        int in_idx    = 0;
        int out_idx   = 0;
        int stall_cnt = 0;
        int extra     = 0;
        m[0] = 48'h4000_0000_0000; er[0] = 32'h3F80_0000;
        m[1] = 48'h4000_00C0_0000; er[1] = 32'h3F80_0002;
        m[2] = 48'h8000_0000_0000; er[2] = 32'h4000_0000;
        m[3] = 48'h4000_0080_0000; er[3] = 32'h3F80_0001;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            ready_i = !(cyc >= 2 && cyc <= 5);
            valid_i = (in_idx < 4);
            if (in_idx < 4) begin
                sign_in = 1'b0;
                exp_in  = 10'sd127;
                mant_in = m[in_idx];
            end
            #1;
            if (valid_i && !ready_o) stall_cnt++;
            if (valid_o) begin
                if (out_idx < 4) begin
                    checks++;
                    if (result !== er[out_idx]) begin
                        errors++;
                        $display("FAIL b2b_out%0d (ready_i=%b): got %h expected %h", out_idx, ready_i, result, er[out_idx]);
                    end
                    if (ready_i) out_idx++;
                end else if (ready_i) begin
                    extra++;
                end
            end
            if (valid_i && ready_o) in_idx++;
        end
        @(negedge clk);
        valid_i = 1'b0;
        checks++;
        if (stall_cnt == 0) begin errors++; $display("FAIL b2b_ready_drop: got %0d stalled cycles expected >0", stall_cnt); end
        checks++;
        if (out_idx != 4) begin errors++; $display("FAIL b2b_count: got %0d results expected 4", out_idx); end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL b2b_dup: got %0d extra results expected 0", extra); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res;
        logic [3:0]  fl;
        logic        lat;
        int          stray = 0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sign_in = 1'b0; exp_in = 10'sd127; mant_in = 48'h4000_0000_0000; valid_i = 1'b1;
        @(negedge clk);
        mant_in = 48'h4000_0080_0000;
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        ready_i = 1'b1;
        checks++;
        if (result !== 32'h0) begin errors++; $display("FAIL rst_mid_result: got %h expected 00000000", result); end
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", ready_o); end
        for (int i = 0; i < 6; i++) begin
            if (valid_o !== 1'b0) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL rst_mid_stray: got %0d valid cycles expected 0", stray); end
        run_op(1'b0, 10'sd128, 48'h4000_0000_0000, res, fl, lat);
        checks++;
        if (lat !== 1'b1) begin errors++; $display("FAIL rst_fresh_latency: got ok=%b expected ok=1", lat); end
        checks++;
        if (res !== 32'h4000_0000) begin errors++; $display("FAIL rst_fresh_result: got %h expected 40000000", res); end
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        sign_in = 1'b0;
        exp_in  = '0;
        mant_in = '0;
        test_reset();
        test_normalize_round();
        test_carry_overflow();
        test_zero_underflow();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
